// File: rtl/mux_tree_pipe_pkg.sv
// rtl/mux_tree_pipe_pkg.sv - shared sizing helpers for the pipelined select tree
package mux_tree_pipe_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_SEL_W = 4;

  // Number of 4:1 levels, which is also the pipeline latency in cycles.
  function automatic int levels_f(input int sel_w);
    return (sel_w + 1) / 2;
  endfunction

  // Words on the flattened bus; word k lives at bits [k*n +: n].
  function automatic int words_f(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// rtl/mux_tree_pipe_if.sv - select/handshake bundle between ALU units and writeback
interface mux_tree_pipe_if
  import mux_tree_pipe_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = DEF_SEL_W
);

  logic [N*words_f(SEL_W)-1:0] x;
  logic [SEL_W-1:0]            c;
  logic                        in_valid;
  logic                        in_ready;
  logic [N-1:0]                r;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output x, c, in_valid, out_ready,
    input  in_ready, r, out_valid
  );

  modport slave (
    input  x, c, in_valid, out_ready,
    output in_ready, r, out_valid
  );

endinterface

// File: rtl/mux_4to1.sv
// rtl/mux_4to1.sv - combinational 4:1 word selector
module mux_4to1 #(
  parameter int N = 32
) (
  input  logic [4*N-1:0] d,
  input  logic [1:0]     s,
  output logic [N-1:0]   y
);

  always_comb begin
    y = d[0 +: N];
    case (s)
      2'd1:    y = d[N +: N];
      2'd2:    y = d[2*N +: N];
      2'd3:    y = d[3*N +: N];
      default: y = d[0 +: N];
    endcase
  end

endmodule

// File: rtl/mux_tree_pipe_mux_4to1_reg.sv
// rtl/mux_tree_pipe_mux_4to1_reg.sv - one tree level: GROUPS 4:1 muxes plus an elastic register
module mux_tree_pipe_mux_4to1_reg #(
  parameter int N      = 32,
  parameter int GROUPS = 1,
  parameter int SW     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [4*GROUPS*N-1:0]            in_data,
  input  logic [SW-1:0]                    in_sel,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [GROUPS*N-1:0]              out_data,
  output logic [((SW > 2) ? SW-2 : 1)-1:0] out_sel,
  output logic                             out_valid,
  input  logic                             out_ready
);

  logic [GROUPS*N-1:0] mux_y;

  // Loading whenever empty squeezes bubbles out during a downstream stall.
  assign in_ready = !out_valid || out_ready;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    mux_4to1 #(.N(N)) u_mux (
      .d (in_data[g*4*N +: 4*N]),
      .s (in_sel[1:0]),
      .y (mux_y[g*N +: N])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= mux_y;
    end
  end

  if (SW > 2) begin : g_sel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_sel <= '0;
      end else if (in_ready) begin
        out_sel <= in_sel[SW-1:2];
      end
    end
  end else begin : g_nosel
    assign out_sel = 1'b0;
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined 2**SEL_W-to-1 word selector, one register per 4:1 level
module mux_tree_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_tree_pipe_if.slave  bus
);

  localparam int LEVELS  = levels_f(SEL_W);
  localparam int SEL_P   = 2 * LEVELS;
  localparam int WORDS   = words_f(SEL_W);
  localparam int WORDS_P = words_f(SEL_P);

  logic [WORDS_P*N-1:0] x_pad;
  logic [SEL_P-1:0]     c_pad;

  // Odd SEL_W: top level degenerates to 2:1 via a zero select bit and zero words.
  if (SEL_P == SEL_W) begin : g_even
    assign x_pad = bus.x;
    assign c_pad = bus.c;
  end else begin : g_odd
    assign x_pad = {{((WORDS_P - WORDS) * N){1'b0}}, bus.x};
    assign c_pad = {1'b0, bus.c};
  end

  for (genvar i = 0; i < LEVELS; i++) begin : lvl
    localparam int GROUPS = 1 << (2 * (LEVELS - 1 - i));
    localparam int SW     = 2 * (LEVELS - i);
    localparam int SOW    = (SW > 2) ? SW - 2 : 1;

    logic [4*GROUPS*N-1:0] din;
    logic [SW-1:0]         sin;
    logic                  vin;
    logic                  rdy;
    logic [GROUPS*N-1:0]   dout;
    logic [SOW-1:0]        sout;
    logic                  vout;
    logic                  nrdy;

    if (i == 0) begin : g_head
      assign din = x_pad;
      assign sin = c_pad;
      assign vin = bus.in_valid;
    end else begin : g_link
      assign din = lvl[i-1].dout;
      assign sin = lvl[i-1].sout;
      assign vin = lvl[i-1].vout;
    end

    if (i == LEVELS - 1) begin : g_tail
      logic unused_sel;
      assign nrdy       = bus.out_ready;
      assign unused_sel = |sout;
    end else begin : g_mid
      assign nrdy = lvl[i+1].rdy;
    end

    mux_tree_pipe_mux_4to1_reg #(
      .N      (N),
      .GROUPS (GROUPS),
      .SW     (SW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (din),
      .in_sel    (sin),
      .in_valid  (vin),
      .in_ready  (rdy),
      .out_data  (dout),
      .out_sel   (sout),
      .out_valid (vout),
      .out_ready (nrdy)
    );
  end

  assign bus.in_ready  = lvl[0].rdy;
  assign bus.r         = lvl[LEVELS-1].dout;
  assign bus.out_valid = lvl[LEVELS-1].vout;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - scoreboard bench for mux_tree_pipe (N=32/SEL_W=4 and N=8/SEL_W=3)
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_tree_pipe_if #(.N(32), .SEL_W(4)) bus0 ();
  mux_tree_pipe_if #(.N(8),  .SEL_W(3)) bus1 ();

  mux_tree_pipe #(.N(32), .SEL_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux_tree_pipe #(.N(8),  .SEL_W(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [31:0] x0w [16];
  logic [7:0]  x1w [8];
  logic [31:0] q0 [$];
  logic [7:0]  q1 [$];
  int n_checks = 0;
  int n_pass   = 0;

  for (genvar k = 0; k < 16; k++) begin : g_x0
    assign bus0.x[k*32 +: 32] = x0w[k];
  end
  for (genvar k = 0; k < 8; k++) begin : g_x1
    assign bus1.x[k*8 +: 8] = x1w[k];
  end

  task automatic set_base();
    for (int k = 0; k < 16; k++) x0w[k] = 32'hA000_0000 + k;
    for (int k = 0; k < 8; k++)  x1w[k] = 8'h10 + 8'(k);
  endtask

  // Advance one cycle; record accepts into the scoreboard and capture outputs before the edge.
  task automatic tick(output bit a0, output bit v0, output logic [31:0] r0,
                      output bit a1, output bit v1, output logic [7:0] r1);
    @(negedge clk);
    a0 = bus0.in_valid && bus0.in_ready;
    a1 = bus1.in_valid && bus1.in_ready;
    if (a0) q0.push_back(x0w[bus0.c]);
    if (a1) q1.push_back(x1w[bus1.c]);
    v0 = bus0.out_valid;
    r0 = bus0.r;
    v1 = bus1.out_valid;
    r1 = bus1.r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_base();
    bus0.in_valid = 1'b1; bus0.c = 4'd9; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b1; bus1.c = 3'd6; bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus0.out_valid !== 1'b0) $display("FAIL reset_ov0: got %b want 0", bus0.out_valid); else n_pass++;
    n_checks++; if (bus0.r !== 32'h0) $display("FAIL reset_r0: got %h want 0", bus0.r); else n_pass++;
    n_checks++; if (bus1.out_valid !== 1'b0 || bus1.r !== 8'h0) $display("FAIL reset_dut1: got %b/%h want 0/00", bus1.out_valid, bus1.r); else n_pass++;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b/%b want 1/1", bus0.in_ready, bus1.in_ready); else n_pass++;
  endtask

  task automatic test_fill();
    bit a0, v0, a1, v1; logic [31:0] r0; logic [7:0] r1; logic [31:0] e;
    bus0.c = 4'd9; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
    tick(a0, v0, r0, a1, v1, r1);
    n_checks++; if (a0 !== 1'b1) $display("FAIL fill_accept: got %b want 1", a0); else n_pass++;
    bus0.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(a0, v0, r0, a1, v1, r1);
      n_checks++; if (v0 !== (k == 2)) $display("FAIL fill_valid_cycle%0d: got %b want %b", k, v0, (k == 2)); else n_pass++;
      if (v0) begin
        n_checks++; if (r0 !== 32'hA000_0009) $display("FAIL fill_r: got %h want a0000009", r0); else n_pass++;
        e = (q0.size() > 0) ? q0.pop_front() : 32'hx;
        n_checks++; if (r0 !== e) $display("FAIL fill_sb: got %h want %h", r0, e); else n_pass++;
      end
    end
  endtask

  task automatic test_stream();
    bit a0, v0, a1, v1; logic [31:0] r0; logic [7:0] r1; logic [31:0] e;
    int first = -1, last = -1, got = 0, drops = 0;
    bus0.out_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      bus0.in_valid = (cyc < 16);
      bus0.c = cyc[3:0];
      tick(a0, v0, r0, a1, v1, r1);
      if (cyc < 16 && !a0) drops++;
      if (v0) begin
        if (first < 0) first = cyc;
        last = cyc;
        got++;
        e = (q0.size() > 0) ? q0.pop_front() : 32'hx;
        n_checks++; if (r0 !== e) $display("FAIL stream_r: got %h want %h", r0, e); else n_pass++;
      end
    end
    n_checks++; if (drops != 0) $display("FAIL stream_in_ready: got %0d stalled cycles want 0", drops); else n_pass++;
    n_checks++; if (first != 2 || last != 17) $display("FAIL stream_window: got %0d..%0d want 2..17", first, last); else n_pass++;
    n_checks++; if (got != 16) $display("FAIL stream_count: got %0d want 16", got); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit a0, v0, a1, v1; logic [31:0] r0; logic [7:0] r1; logic [31:0] e;
    logic [3:0] seq [4];
    logic [31:0] outs [$];
    int idx = 0;
    seq[0] = 4'd3; seq[1] = 4'd5; seq[2] = 4'd7; seq[3] = 4'd11;
    bus0.out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      bus0.in_valid = 1'b1;
      bus0.c = seq[idx];
      tick(a0, v0, r0, a1, v1, r1);
      if (a0) idx++;
      if (cyc >= 2) begin
        n_checks++; if (a0 !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %b want 0", cyc, a0); else n_pass++;
        n_checks++; if (v0 !== 1'b1 || r0 !== 32'hA000_0003) $display("FAIL bp_hold_c%0d: got %b/%h want 1/a0000003", cyc, v0, r0); else n_pass++;
      end
    end
    n_checks++; if (idx != 2) $display("FAIL bp_accepted: got %0d want 2", idx); else n_pass++;
    bus0.out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus0.in_valid = (idx < 4);
      bus0.c = seq[(idx < 4) ? idx : 3];
      tick(a0, v0, r0, a1, v1, r1);
      if (cyc == 0) begin
        n_checks++; if (a0 !== 1'b1 || v0 !== 1'b1) $display("FAIL bp_release_both: got in=%b out=%b want 1/1", a0, v0); else n_pass++;
      end
      if (a0) idx++;
      if (v0) begin
        outs.push_back(r0);
        e = (q0.size() > 0) ? q0.pop_front() : 32'hx;
        n_checks++; if (r0 !== e) $display("FAIL bp_sb: got %h want %h", r0, e); else n_pass++;
      end
    end
    n_checks++; if (outs.size() != 4) $display("FAIL bp_count: got %0d want 4", outs.size()); else n_pass++;
    for (int j = 0; j < 4 && j < outs.size(); j++) begin
      n_checks++; if (outs[j] !== 32'hA000_0000 + seq[j]) $display("FAIL bp_order%0d: got %h want %h", j, outs[j], 32'hA000_0000 + seq[j]); else n_pass++;
    end
  endtask

  task automatic test_odd();
    bit a0, v0, a1, v1; logic [31:0] r0; logic [7:0] r1; logic [7:0] e;
    bus0.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      bus1.in_valid = (cyc < 2);
      bus1.c = (cyc == 0) ? 3'd6 : 3'd3;
      tick(a0, v0, r0, a1, v1, r1);
      n_checks++; if (v1 !== (cyc == 2 || cyc == 3)) $display("FAIL odd_valid_c%0d: got %b want %b", cyc, v1, (cyc == 2 || cyc == 3)); else n_pass++;
      if (cyc == 2) begin
        n_checks++; if (r1 !== 8'h16) $display("FAIL odd_r6: got %h want 16", r1); else n_pass++;
      end
      if (cyc == 3) begin
        n_checks++; if (r1 !== 8'h13) $display("FAIL odd_r3: got %h want 13", r1); else n_pass++;
      end
      if (v1) begin
        e = (q1.size() > 0) ? q1.pop_front() : 8'hx;
        n_checks++; if (r1 !== e) $display("FAIL odd_sb: got %h want %h", r1, e); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit a0, v0, a1, v1; logic [31:0] r0; logic [7:0] r1; logic [31:0] e;
    int spurious = 0, got = 0;
    bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      bus0.in_valid = 1'b1;
      bus0.c = 4'(cyc + 1);
      tick(a0, v0, r0, a1, v1, r1);
    end
    bus0.in_valid = 1'b0;
    n_checks++; if (bus0.out_valid !== 1'b1) $display("FAIL mid_inflight: got %b want 1", bus0.out_valid); else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus0.out_valid !== 1'b0 || bus0.r !== 32'h0) $display("FAIL mid_async_clear: got %b/%h want 0/0", bus0.out_valid, bus0.r); else n_pass++;
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick(a0, v0, r0, a1, v1, r1);
      if (v0 || v1) spurious++;
    end
    n_checks++; if (spurious != 0) $display("FAIL mid_no_output: got %0d outputs want 0", spurious); else n_pass++;
    for (int cyc = 0; cyc < 5; cyc++) begin
      bus0.in_valid = (cyc == 0);
      bus0.c = 4'd12;
      tick(a0, v0, r0, a1, v1, r1);
      if (v0) begin
        got++;
        e = (q0.size() > 0) ? q0.pop_front() : 32'hx;
        n_checks++; if (r0 !== e || r0 !== 32'hA000_000C) $display("FAIL mid_new_word: got %h want a000000c", r0); else n_pass++;
      end
    end
    n_checks++; if (got != 1) $display("FAIL mid_new_count: got %0d want 1", got); else n_pass++;
  endtask

  task automatic test_random();
    bit a0, v0, a1, v1; logic [31:0] r0; logic [7:0] r1; logic [31:0] e0; logic [7:0] e1;
    bit hold0 = 0, hold1 = 0; logic [31:0] last0 = '0; logic [7:0] last1 = '0;
    for (int cyc = 0; cyc < 10006; cyc++) begin
      for (int k = 0; k < 16; k++) x0w[k] = $urandom;
      for (int k = 0; k < 8; k++)  x1w[k] = 8'($urandom);
      bus0.in_valid  = (cyc < 10000) && ($urandom_range(0, 1) != 0);
      bus1.in_valid  = (cyc < 10000) && ($urandom_range(0, 1) != 0);
      bus0.c         = 4'($urandom_range(0, 15));
      bus1.c         = 3'($urandom_range(0, 7));
      bus0.out_ready = (cyc >= 10000) || ($urandom_range(0, 3) != 0);
      bus1.out_ready = (cyc >= 10000) || ($urandom_range(0, 3) != 0);
      tick(a0, v0, r0, a1, v1, r1);
      if (hold0) begin
        n_checks++; if (v0 !== 1'b1 || r0 !== last0) $display("FAIL rnd_stall0: got %b/%h want 1/%h", v0, r0, last0); else n_pass++;
      end
      if (hold1) begin
        n_checks++; if (v1 !== 1'b1 || r1 !== last1) $display("FAIL rnd_stall1: got %b/%h want 1/%h", v1, r1, last1); else n_pass++;
      end
      hold0 = v0 && !bus0.out_ready; last0 = r0;
      hold1 = v1 && !bus1.out_ready; last1 = r1;
      if (v0 && bus0.out_ready) begin
        e0 = (q0.size() > 0) ? q0.pop_front() : 32'hx;
        n_checks++; if (r0 !== e0) $display("FAIL rnd_r0 cyc %0d: got %h want %h", cyc, r0, e0); else n_pass++;
      end
      if (v1 && bus1.out_ready) begin
        e1 = (q1.size() > 0) ? q1.pop_front() : 8'hx;
        n_checks++; if (r1 !== e1) $display("FAIL rnd_r1 cyc %0d: got %h want %h", cyc, r1, e1); else n_pass++;
      end
    end
    n_checks++; if (q0.size() != 0 || q1.size() != 0) $display("FAIL rnd_drain: got %0d/%0d pending want 0/0", q0.size(), q1.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_backpressure();
    test_odd();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
